// File: rtl/trigger_merge_n.sv
// trigger_merge_n: priority-merges NSRC trigger sources with dead-time lockout,
// a one-deep pending store and forwarded/dropped counters.
module trigger_merge_n #(
  parameter int NSRC = 4,
  parameter int DTW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic [5*NSRC-1:0] src,
  input  logic [NSRC-1:0]   src_ena,
  input  logic [DTW-1:0]    dead_time,
  input  logic              pend_ena,
  input  logic              clear,
  output logic [4:0]        trg_out,
  output logic [2:0]        trg_src,
  output logic              trg_valid,
  output logic              busy,
  output logic [31:0]       trg_count,
  output logic [15:0]       drop_count
);
  typedef enum logic {IDLE, DEAD} state_t;
  state_t state, state_nxt;
  logic [DTW-1:0] dcnt;
  logic [NSRC-1:0] req;
  logic [4:0] win_code, pend_code;
  logic [2:0] win_idx, pend_idx;
  logic pend_v, any, multi, fwd_pend, fwd_new, fwd, cap, drop;
  always_comb begin
    req = '0;
    win_code = '0;
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      req[i] = src_ena[i] && |src[5*i +: 5];
      if (req[i]) begin
        win_code = src[5*i +: 5];
        win_idx = 3'(i);
      end
    end
  end
  assign any = |req;
  assign multi = |(req & (req - NSRC'(1)));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else if (sync) state <= clear ? IDLE : state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? ((fwd && dead_time != '0) ? DEAD : IDLE)
                                : ((dcnt == '0) ? IDLE : DEAD);
  // A pending trigger takes the IDLE slot ahead of anything new that cycle.
  always_comb begin
    busy = state == DEAD;
    fwd_pend = !busy && pend_v;
    fwd_new = !busy && !pend_v && any;
    fwd = fwd_pend || fwd_new;
    cap = busy && any && pend_ena && !pend_v;
    drop = (fwd_new || cap) ? multi : any;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      trg_out <= '0;
      trg_src <= '0;
      trg_valid <= 1'b0;
      trg_count <= '0;
      drop_count <= '0;
      dcnt <= '0;
      pend_v <= 1'b0;
      pend_code <= '0;
      pend_idx <= '0;
    end else if (sync) begin
      if (clear) begin
        trg_valid <= 1'b0;
        trg_count <= '0;
        drop_count <= '0;
        dcnt <= '0;
        pend_v <= 1'b0;
      end else begin
        trg_valid <= fwd;
        if (fwd) begin
          trg_out <= fwd_pend ? pend_code : win_code;
          trg_src <= fwd_pend ? pend_idx : win_idx;
          trg_count <= trg_count + 32'd1;
        end
        if (fwd && dead_time != '0) dcnt <= dead_time - DTW'(1);
        else if (busy && dcnt != '0) dcnt <= dcnt - DTW'(1);
        if (fwd_pend) pend_v <= 1'b0;
        else if (cap) begin
          pend_v <= 1'b1;
          pend_code <= win_code;
          pend_idx <= win_idx;
        end
        if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
endmodule

// File: tb/tb_trigger_merge_n.sv
// tb_trigger_merge_n: table-driven directed vectors plus hand sequences for
// counter saturation, clear and asynchronous reset during lockout.
module tb_trigger_merge_n;
  logic clk = 1'b0, reset = 1'b0, sync = 1'b0, clear = 1'b0, pend_ena = 1'b0;
  logic [19:0] src = '0;
  logic [3:0] src_ena = '0;
  logic [15:0] dead_time = '0;
  logic [4:0] trg_out;
  logic [2:0] trg_src;
  logic trg_valid, busy;
  logic [31:0] trg_count;
  logic [15:0] drop_count;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic sy, cl, pe;
    logic [3:0] en;
    logic [15:0] dt;
    logic [19:0] s;
    logic [4:0] o;
    logic [2:0] si;
    logic v, b;
    logic [31:0] tc;
    logic [15:0] dc;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  trigger_merge_n #(.NSRC(4), .DTW(16)) dut (
    .clk(clk), .reset(reset), .sync(sync), .src(src), .src_ena(src_ena),
    .dead_time(dead_time), .pend_ena(pend_ena), .clear(clear),
    .trg_out(trg_out), .trg_src(trg_src), .trg_valid(trg_valid), .busy(busy),
    .trg_count(trg_count), .drop_count(drop_count)
  );
  function automatic logic [19:0] s4(logic [4:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction
  function automatic vec_t vx(logic sy, cl, pe, logic [3:0] en, logic [15:0] dt, logic [19:0] s,
                              logic [4:0] o, logic [2:0] si, logic v, b, logic [31:0] tc, logic [15:0] dc);
    vec_t r;
    r.sy = sy; r.cl = cl; r.pe = pe; r.en = en; r.dt = dt; r.s = s;
    r.o = o; r.si = si; r.v = v; r.b = b; r.tc = tc; r.dc = dc;
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string name, input logic [4:0] o, input logic [2:0] si, input logic v, b,
                         input logic [31:0] tc, input logic [15:0] dc);
    chk(name, {6'd0, trg_out, trg_src, trg_valid, busy, trg_count, drop_count}, {6'd0, o, si, v, b, tc, dc});
  endtask
  task automatic drive(input logic sy, cl, pe, input logic [3:0] en, input logic [15:0] dt, input logic [19:0] s);
    @(negedge clk);
    sync = sy; clear = cl; pend_ena = pe; src_ena = en; dead_time = dt; src = s;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // field order: sync clear pend_ena src_ena dead_time src | trg_out trg_src valid busy trg_count drop_count
    tbl.push_back(vx(1, 0, 0, 4'hF, 0, s4(5'h01, 0, 5'h08, 0), 5'h01, 0, 1, 0, 1, 1));
    tbl.push_back(vx(1, 0, 0, 4'hF, 0, s4(0, 0, 0, 0), 5'h01, 0, 0, 0, 1, 1));
    tbl.push_back(vx(1, 0, 0, 4'hF, 0, s4(0, 5'h02, 0, 0), 5'h02, 1, 1, 0, 2, 1));
    tbl.push_back(vx(1, 0, 0, 4'hF, 0, s4(0, 0, 0, 5'h04), 5'h04, 3, 1, 0, 3, 1));
    tbl.push_back(vx(0, 0, 0, 4'hF, 0, s4(5'h01, 0, 0, 0), 5'h04, 3, 1, 0, 3, 1));
    tbl.push_back(vx(1, 0, 0, 4'hF, 0, s4(0, 0, 0, 0), 5'h04, 3, 0, 0, 3, 1));
    tbl.push_back(vx(1, 0, 0, 4'hF, 3, s4(0, 5'h01, 0, 0), 5'h01, 1, 1, 1, 4, 1));
    tbl.push_back(vx(1, 0, 0, 4'hF, 3, s4(0, 0, 0, 0), 5'h01, 1, 0, 1, 4, 1));
    tbl.push_back(vx(1, 0, 0, 4'hF, 3, s4(0, 5'h01, 0, 0), 5'h01, 1, 0, 1, 4, 2));
    tbl.push_back(vx(1, 0, 0, 4'hF, 3, s4(0, 0, 0, 0), 5'h01, 1, 0, 0, 4, 2));
    tbl.push_back(vx(1, 0, 0, 4'hF, 3, s4(0, 5'h01, 0, 0), 5'h01, 1, 1, 1, 5, 2));
    tbl.push_back(vx(1, 0, 0, 4'hF, 1, s4(0, 0, 0, 0), 5'h01, 1, 0, 1, 5, 2));
    tbl.push_back(vx(1, 0, 0, 4'hF, 1, s4(0, 0, 0, 0), 5'h01, 1, 0, 1, 5, 2));
    tbl.push_back(vx(1, 0, 0, 4'hF, 1, s4(0, 0, 0, 0), 5'h01, 1, 0, 0, 5, 2));
    tbl.push_back(vx(1, 0, 0, 4'hF, 1, s4(0, 0, 5'h01, 0), 5'h01, 2, 1, 1, 6, 2));
    tbl.push_back(vx(1, 0, 0, 4'hF, 1, s4(0, 0, 0, 0), 5'h01, 2, 0, 0, 6, 2));
    tbl.push_back(vx(1, 0, 1, 4'hF, 3, s4(0, 0, 0, 5'h04), 5'h04, 3, 1, 1, 7, 2));
    tbl.push_back(vx(1, 0, 1, 4'hF, 3, s4(0, 5'h01, 0, 0), 5'h04, 3, 0, 1, 7, 2));
    tbl.push_back(vx(1, 0, 1, 4'hF, 3, s4(0, 0, 5'h01, 0), 5'h04, 3, 0, 1, 7, 3));
    tbl.push_back(vx(1, 0, 1, 4'hF, 3, s4(0, 0, 0, 0), 5'h04, 3, 0, 0, 7, 3));
    tbl.push_back(vx(1, 0, 1, 4'hF, 3, s4(5'h02, 0, 0, 0), 5'h01, 1, 1, 1, 8, 4));
    tbl.push_back(vx(1, 0, 1, 4'hF, 3, s4(0, 0, 0, 0), 5'h01, 1, 0, 1, 8, 4));
    tbl.push_back(vx(1, 0, 1, 4'hF, 3, s4(0, 0, 0, 0), 5'h01, 1, 0, 1, 8, 4));
    tbl.push_back(vx(1, 0, 1, 4'hF, 3, s4(0, 0, 0, 0), 5'h01, 1, 0, 0, 8, 4));
    tbl.push_back(vx(1, 0, 0, 4'hE, 0, s4(5'h01, 0, 0, 0), 5'h01, 1, 0, 0, 8, 4));
    tbl.push_back(vx(1, 0, 0, 4'hE, 0, s4(5'h01, 0, 0, 0), 5'h01, 1, 0, 0, 8, 4));
    tbl.push_back(vx(1, 0, 0, 4'hE, 0, s4(5'h01, 5'h08, 0, 0), 5'h08, 1, 1, 0, 9, 4));
    tbl.push_back(vx(1, 1, 0, 4'hF, 0, s4(5'h01, 0, 0, 0), 5'h08, 1, 0, 0, 0, 0));
    tbl.push_back(vx(1, 0, 0, 4'hF, 0, s4(5'h01, 0, 0, 0), 5'h01, 0, 1, 0, 1, 0));
    // reset held: requests with sync=1 must not change anything
    sync = 1'b1; src_ena = 4'hF; src = s4(5'h01, 0, 0, 0);
    @(posedge clk); #1;
    chk_out("reset_hold", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    sync = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk_out("release_nosync", 0, 0, 0, 0, 0, 0);
    foreach (tbl[k]) begin
      drive(tbl[k].sy, tbl[k].cl, tbl[k].pe, tbl[k].en, tbl[k].dt, tbl[k].s);
      chk_out($sformatf("vec%0d", k), tbl[k].o, tbl[k].si, tbl[k].v, tbl[k].b, tbl[k].tc, tbl[k].dc);
    end
    // two requests every cycle: one forwarded, one dropped, until saturation
    for (int i = 0; i < 65534; i++) drive(1, 0, 0, 4'hF, 0, s4(5'h01, 5'h01, 0, 0));
    chk("drop_fffe", {48'd0, drop_count}, 64'h0000_0000_0000_FFFE);
    drive(1, 0, 0, 4'hF, 0, s4(5'h01, 5'h01, 0, 0));
    chk("drop_ffff", {48'd0, drop_count}, 64'h0000_0000_0000_FFFF);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 4'hF, 0, s4(5'h01, 5'h01, 0, 0));
    chk_out("drop_sat", 5'h01, 0, 1, 0, 32'd65539, 16'hFFFF);
    drive(1, 0, 0, 4'hF, 4, s4(5'h01, 0, 0, 0));
    chk_out("dead_before_clear", 5'h01, 0, 1, 1, 32'd65540, 16'hFFFF);
    drive(1, 1, 0, 4'hF, 4, s4(5'h01, 0, 0, 0));
    chk_out("clear", 5'h01, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 4'hF, 4, s4(0, 0, 0, 0));
    chk_out("after_clear_idle", 5'h01, 0, 0, 0, 0, 0);
    // asynchronous reset while locked out with a pending trigger stored
    drive(1, 0, 1, 4'hF, 5, s4(5'h01, 0, 0, 0));
    chk_out("ar_fwd", 5'h01, 0, 1, 1, 1, 0);
    drive(1, 0, 1, 4'hF, 5, s4(0, 5'h02, 0, 0));
    chk_out("ar_capture", 5'h01, 0, 0, 1, 1, 0);
    @(negedge clk);
    sync = 1'b0; src = '0;
    #2 reset = 1'b0;
    #1 chk_out("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, 4'hF, 5, s4(0, 0, 0, 0));
      chk($sformatf("no_pend_fwd%0d", i), {31'd0, trg_valid, trg_count}, 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
